// File: rtl/hazard_scoreboard.sv
// Register scoreboard for the 4-stage pipeline: per-register latency countdowns drive the
// front-end stall and E-stage bubble for variable-latency producers (ALU, load, MUL/DIV).
module hazard_scoreboard #(
  parameter int REG_SIZE = 5,
  parameter int NREGS    = 32,
  parameter int LAT_W    = 4,
  parameter int STAT_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validD,
  input  logic [REG_SIZE-1:0] raddr1D,
  input  logic [REG_SIZE-1:0] raddr2D,
  input  logic                use1D,
  input  logic                use2D,
  input  logic [REG_SIZE-1:0] rdD,
  input  logic                regWriteD,
  input  logic [LAT_W-1:0]    latD,
  input  logic                mcD,
  input  logic                flush,
  output logic                stallF,
  output logic                stallD,
  output logic                flushE,
  output logic [NREGS-1:0]    busy,
  output logic [STAT_W-1:0]   stall_cnt
);

  logic [LAT_W-1:0]    cnt_q [1:NREGS-1];
  logic [LAT_W-1:0]    cnt_d [1:NREGS-1];
  logic [LAT_W-1:0]    mc_cnt_q, mc_cnt_d;
  logic [REG_SIZE-1:0] last_rd_q, last_rd_d;
  logic                last_we_q, last_we_d;
  logic                last_mc_q, last_mc_d;
  logic [STAT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [NREGS-1:0] busy_w;
  logic             raw1, raw2, waw, struct_haz, haz, issue, wr_en;
  logic [LAT_W-1:0] lat_m1;

  // x0 is never tracked, so its pending bit is a constant zero.
  assign busy_w[0] = 1'b0;
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
    assign busy_w[gi] = (cnt_q[gi] != '0);
  end

  assign raw1       = use1D & (raddr1D != '0) & busy_w[raddr1D];
  assign raw2       = use2D & (raddr2D != '0) & busy_w[raddr2D];
  assign waw        = regWriteD & (rdD != '0) & busy_w[rdD];
  assign struct_haz = mcD & (mc_cnt_q != '0);
  assign haz        = validD & ~flush & (raw1 | raw2 | waw | struct_haz);
  assign issue      = validD & ~haz & ~flush;
  assign wr_en      = issue & regWriteD & (rdD != '0);
  // Latency 0 behaves as 1: the result is forwardable on the very next cycle.
  assign lat_m1     = (latD == '0) ? '0 : latD - LAT_W'(1);

  always_comb begin
    for (int r = 1; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (flush && last_we_q && (last_rd_q == REG_SIZE'(r))) begin
        cnt_d[r] = '0;
      end else if (wr_en && (rdD == REG_SIZE'(r))) begin
        cnt_d[r] = lat_m1;
      end
    end

    mc_cnt_d = (mc_cnt_q != '0) ? mc_cnt_q - LAT_W'(1) : '0;
    if (flush && last_mc_q) begin
      mc_cnt_d = '0;
    end else if (issue && mcD) begin
      mc_cnt_d = lat_m1;
    end

    // issue is already low under flush, so the squashed record clears itself.
    last_we_d = wr_en;
    last_rd_d = rdD;
    last_mc_d = issue & mcD;

    stall_cnt_d = stall_cnt_q;
    if (haz && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      mc_cnt_q    <= '0;
      last_rd_q   <= '0;
      last_we_q   <= 1'b0;
      last_mc_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      mc_cnt_q    <= mc_cnt_d;
      last_rd_q   <= last_rd_d;
      last_we_q   <= last_we_d;
      last_mc_q   <= last_mc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Gate with reset so a flush request cannot leak a bubble while held in reset.
  assign stallF    = reset & haz;
  assign stallD    = reset & haz;
  assign flushE    = reset & (haz | flush);
  assign busy      = busy_w;
  assign stall_cnt = stall_cnt_q;

endmodule
